bcd_score_counter: RTL and testbench

Parametrised N-digit BCD score counter for the VGA game datapath, the next generation of the fixed two-digit 0-99 counter. It supports variable-step increment, decrement, clear and parallel load, and has selectable wrap or saturate behaviour at the boundaries. Digits feed the on-screen text/score renderer directly; status flags feed game-control FSMs.

---
 rtl/bcd_score_counter_if.sv | 37 +++
 rtl/bcd_score_counter.sv | 119 +++++++++++
 tb/tb_bcd_score_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_score_counter_if.sv
// Command/status bundle for bcd_score_counter; NUM_DIGITS must match the counter instance.
// HISCORE_EN adds the high-score outputs hi_digits/new_hi.
interface bcd_score_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    d_clr;
  logic                    d_ld;
  logic [4*NUM_DIGITS-1:0] ld_val;
  logic                    d_inc;
  logic [3:0]              inc_amt;
  logic                    d_dec;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    ovf;
  logic                    unf;
  logic                    at_max;
  logic                    at_zero;
`ifdef HISCORE_EN
  logic [4*NUM_DIGITS-1:0] hi_digits;
  logic                    new_hi;
`endif

  modport master (
    output d_clr, d_ld, ld_val, d_inc, inc_amt, d_dec,
`ifdef HISCORE_EN
    input  hi_digits, new_hi,
`endif
    input  digits, ovf, unf, at_max, at_zero
  );

  modport slave (
    input  d_clr, d_ld, ld_val, d_inc, inc_amt, d_dec,
`ifdef HISCORE_EN
    output hi_digits, new_hi,
`endif
    output digits, ovf, unf, at_max, at_zero
  );
endinterface

// File: rtl/bcd_score_counter.sv
// N-digit BCD score counter: inc by step, dec by 1, clear, clamped load, wrap or saturate (optional HISCORE_EN high score).
// Latency: 1 cycle from command to digits/ovf/unf; hi_digits/new_hi one cycle after digits.
// Backpressure: none, a command is accepted every cycle; priority reset > clr > ld > inc/dec.
module bcd_score_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int WRAP_MODE  = 1
) (
  input logic                clk,
  input logic                reset,
  bcd_score_counter_if.slave sc
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0] digits_q;
  logic [W-1:0] next_digits;
  logic [W-1:0] ld_clamped;
  logic [W-1:0] inc_res;
  logic [W-1:0] dec_res;
  logic [3:0]   step;
  logic [3:0]   nib;
  logic [4:0]   dsum;
  logic         inc_cy;
  logic         dec_bw;
  logic         ovf_q, unf_q;
  logic         ovf_next, unf_next;

  // Per-digit ripple; after the loop inc_cy is the top carry and dec_bw means the count was zero.
  always_comb begin
    step       = (sc.inc_amt > 4'd9) ? 4'd9 : sc.inc_amt;
    ld_clamped = '0;
    inc_res    = '0;
    dec_res    = '0;
    inc_cy     = 1'b0;
    dec_bw     = 1'b1;
    nib        = '0;
    dsum       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = sc.ld_val[4*i +: 4];
      ld_clamped[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;

      dsum = {1'b0, digits_q[4*i +: 4]} + {4'd0, inc_cy} + ((i == 0) ? {1'b0, step} : 5'd0);
      if (dsum > 5'd9) begin
        inc_res[4*i +: 4] = 4'(dsum - 5'd10);
        inc_cy            = 1'b1;
      end else begin
        inc_res[4*i +: 4] = dsum[3:0];
        inc_cy            = 1'b0;
      end

      if (dec_bw) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          dec_res[4*i +: 4] = 4'd9;
        end else begin
          dec_res[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          dec_bw            = 1'b0;
        end
      end else begin
        dec_res[4*i +: 4] = digits_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    next_digits = digits_q;
    ovf_next    = 1'b0;
    unf_next    = 1'b0;
    if (sc.d_clr) begin
      next_digits = '0;
    end else if (sc.d_ld) begin
      next_digits = ld_clamped;
    end else if (sc.d_inc && !sc.d_dec) begin
      ovf_next    = inc_cy;
      next_digits = (inc_cy && WRAP_MODE == 0) ? ALL_NINES : inc_res;
    end else if (sc.d_dec && !sc.d_inc) begin
      unf_next    = dec_bw;
      next_digits = (dec_bw && WRAP_MODE == 0) ? '0 : dec_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      digits_q <= next_digits;
      ovf_q    <= ovf_next;
      unf_q    <= unf_next;
    end
  end

  assign sc.digits  = digits_q;
  assign sc.ovf     = ovf_q;
  assign sc.unf     = unf_q;
  assign sc.at_max  = (digits_q == ALL_NINES);
  assign sc.at_zero = (digits_q == '0);

`ifdef HISCORE_EN
  logic [W-1:0] hi_q;
  logic         new_hi_q;

  // Digits are always valid BCD, so a plain unsigned compare orders them by decimal magnitude.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      new_hi_q <= 1'b0;
    end else if (digits_q > hi_q) begin
      hi_q     <= digits_q;
      new_hi_q <= 1'b1;
    end else begin
      new_hi_q <= 1'b0;
    end
  end

  assign sc.hi_digits = hi_q;
  assign sc.new_hi    = new_hi_q;
`endif
endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: three instances (4-digit wrap, 4-digit saturate, 2-digit wrap)
// share one command stream and are checked every cycle against an integer model.
module tb_bcd_score_counter;
  logic        clk = 1'b0;
  logic        reset;
  logic        c_clr, c_ld, c_inc, c_dec;
  logic [3:0]  c_amt;
  logic [31:0] c_ld_val;

  always #5 clk = ~clk;

  bcd_score_counter_if #(.NUM_DIGITS(4)) if_w4 ();
  bcd_score_counter_if #(.NUM_DIGITS(4)) if_s4 ();
  bcd_score_counter_if #(.NUM_DIGITS(2)) if_w2 ();

  assign if_w4.d_clr = c_clr;  assign if_s4.d_clr = c_clr;  assign if_w2.d_clr = c_clr;
  assign if_w4.d_ld  = c_ld;   assign if_s4.d_ld  = c_ld;   assign if_w2.d_ld  = c_ld;
  assign if_w4.d_inc = c_inc;  assign if_s4.d_inc = c_inc;  assign if_w2.d_inc = c_inc;
  assign if_w4.d_dec = c_dec;  assign if_s4.d_dec = c_dec;  assign if_w2.d_dec = c_dec;
  assign if_w4.inc_amt = c_amt; assign if_s4.inc_amt = c_amt; assign if_w2.inc_amt = c_amt;
  assign if_w4.ld_val = c_ld_val[15:0];
  assign if_s4.ld_val = c_ld_val[15:0];
  assign if_w2.ld_val = c_ld_val[7:0];

  bcd_score_counter #(.NUM_DIGITS(4), .WRAP_MODE(1)) u_w4 (.clk(clk), .reset(reset), .sc(if_w4));
  bcd_score_counter #(.NUM_DIGITS(4), .WRAP_MODE(0)) u_s4 (.clk(clk), .reset(reset), .sc(if_s4));
  bcd_score_counter #(.NUM_DIGITS(2), .WRAP_MODE(1)) u_w2 (.clk(clk), .reset(reset), .sc(if_w2));

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // ---------------- model: counts held as plain integers ----------------
  int nd[3] = '{4, 4, 2};
  bit wr[3] = '{1'b1, 1'b0, 1'b1};
  int m_val[3];
  bit m_ovf[3];
  bit m_unf[3];
  int m_hi[3];
  bit m_new_hi[3];

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp_dec(input logic [31:0] v, input int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int mx, amt, s;
      mx  = pow10(nd[k]) - 1;
      amt = (c_amt > 4'd9) ? 9 : int'(c_amt);
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      if (reset) begin
        m_hi[k] = 0; m_new_hi[k] = 1'b0;
      end else if (m_val[k] > m_hi[k]) begin
        m_hi[k] = m_val[k]; m_new_hi[k] = 1'b1;
      end else begin
        m_new_hi[k] = 1'b0;
      end
      if (reset || c_clr) begin
        m_val[k] = 0;
      end else if (c_ld) begin
        m_val[k] = clamp_dec(c_ld_val, nd[k]);
      end else if (c_inc && !c_dec) begin
        s = m_val[k] + amt;
        if (s > mx) begin
          m_ovf[k] = 1'b1;
          s = wr[k] ? s - (mx + 1) : mx;
        end
        m_val[k] = s;
      end else if (c_dec && !c_inc) begin
        if (m_val[k] == 0) begin
          m_unf[k] = 1'b1;
          m_val[k] = wr[k] ? mx : 0;
        end else begin
          m_val[k] = m_val[k] - 1;
        end
      end
    end
  end

  task automatic cmp_inst(input string tag, input int k, input logic [31:0] dig,
                          input logic o, input logic u, input logic am, input logic az);
    chk({tag, "_digits"}, dig, to_bcd(m_val[k], nd[k]));
    chk({tag, "_ovf"}, 32'(o), 32'(m_ovf[k]));
    chk({tag, "_unf"}, 32'(u), 32'(m_unf[k]));
    chk({tag, "_at_max"}, 32'(am), 32'(m_val[k] == pow10(nd[k]) - 1));
    chk({tag, "_at_zero"}, 32'(az), 32'(m_val[k] == 0));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("w4", 0, 32'(if_w4.digits), if_w4.ovf, if_w4.unf, if_w4.at_max, if_w4.at_zero);
      cmp_inst("s4", 1, 32'(if_s4.digits), if_s4.ovf, if_s4.unf, if_s4.at_max, if_s4.at_zero);
      cmp_inst("w2", 2, 32'(if_w2.digits), if_w2.ovf, if_w2.unf, if_w2.at_max, if_w2.at_zero);
`ifdef HISCORE_EN
      chk("w4_hi", 32'(if_w4.hi_digits), to_bcd(m_hi[0], 4));
      chk("w4_new_hi", 32'(if_w4.new_hi), 32'(m_new_hi[0]));
      chk("s4_hi", 32'(if_s4.hi_digits), to_bcd(m_hi[1], 4));
      chk("w2_hi", 32'(if_w2.hi_digits), to_bcd(m_hi[2], 2));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic clr, input logic ld, input logic inc, input logic dec,
                     input logic [3:0] amt, input logic [31:0] val);
    c_clr = clr; c_ld = ld; c_inc = inc; c_dec = dec; c_amt = amt; c_ld_val = val;
    tick();
    c_clr = 1'b0; c_ld = 1'b0; c_inc = 1'b0; c_dec = 1'b0; c_amt = 4'd0; c_ld_val = '0;
  endtask

  initial begin
    reset = 1'b1;
    c_clr = 1'b0; c_ld = 1'b0; c_inc = 1'b0; c_dec = 1'b0; c_amt = 4'd0; c_ld_val = '0;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_digits", 32'(if_w4.digits), 32'h0);
    chk("rst_at_zero", 32'(if_w4.at_zero), 32'h1);
    chk("rst_ovf", 32'(if_w4.ovf), 32'h0);

    for (int i = 0; i < 12; i++) cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
    chk("twelve_w2", 32'(if_w2.digits), 32'h12);
    chk("twelve_w4", 32'(if_w4.digits), 32'h0012);
    chk("twelve_at_zero", 32'(if_w2.at_zero), 32'h0);
    chk("twelve_model", to_bcd(m_val[2], 2), 32'h12);

    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h9998);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h0);
    chk("wrap_digits", 32'(if_w4.digits), 32'h0003);
    chk("wrap_ovf", 32'(if_w4.ovf), 32'h1);
    chk("sat_digits", 32'(if_s4.digits), 32'h9999);
    chk("sat_ovf", 32'(if_s4.ovf), 32'h1);
    tick();
    chk("wrap_ovf_one_cycle", 32'(if_w4.ovf), 32'h0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
    chk("sat_at_max_inc", 32'(if_s4.digits), 32'h9999);
    chk("sat_at_max_ovf", 32'(if_s4.ovf), 32'h1);

    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0001);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0);
    chk("dec1_digits", 32'(if_s4.digits), 32'h0000);
    chk("dec1_unf", 32'(if_s4.unf), 32'h0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0);
    chk("dec2_digits", 32'(if_s4.digits), 32'h0000);
    chk("dec2_unf", 32'(if_s4.unf), 32'h1);
    chk("dec2_at_zero", 32'(if_s4.at_zero), 32'h1);
    chk("dec2_wrap_digits", 32'(if_w4.digits), 32'h9999);

    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'hFA27);
    chk("clamp_ld", 32'(if_w4.digits), 32'h9927);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 32'h0);
    chk("clamp_inc", 32'(if_w4.digits), 32'h9936);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0);
    chk("inc_zero", 32'(if_w4.digits), 32'h9936);

    cmd(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 32'h4321);
    chk("prio_clr", 32'(if_w4.digits), 32'h0000);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h1234);
    cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'h0);
    chk("prio_inc_dec", 32'(if_w4.digits), 32'h1234);
    reset = 1'b1;
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h5555);
    reset = 1'b0;
    chk("prio_reset", 32'(if_w4.digits), 32'h0000);

    cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h1000);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0);
    chk("borrow_ripple", 32'(if_w4.digits), 32'h0999);

`ifdef HISCORE_EN
    begin
      int pulses = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      for (int i = 0; i < 6; i++) begin
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h0);
        if (if_w4.new_hi) pulses++;
      end
      tick();
      if (if_w4.new_hi) pulses++;
      chk("hi_run2_digits", 32'(if_w4.digits), 32'h0030);
      chk("hi_kept", 32'(if_w4.hi_digits), 32'h0050);
      chk("hi_no_pulse", 32'(pulses), 32'h0);
    end
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
